// File: rtl/mem_resp_ctrl.sv
// mem_resp_ctrl: fixed-latency word memory responder for the M stage.
// Accepts one load or store in IDLE and holds the pipeline with stall until the
// access completes. It rejects malformed requests with a single-cycle err pulse.
// A createDump request latches a sticky halt, which freezes the block until reset.
module mem_resp_ctrl #(
  parameter int LATENCY        = 4,
  parameter int MEM_DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        readEn,
  input  logic        memWrt,
  input  logic [15:0] dataAddr,
  input  logic [15:0] wrtData,
  input  logic        createDump,
  output logic [15:0] readData,
  output logic        done,
  output logic        stall,
  output logic        err,
  output logic        halted
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_BUSY   = 1'b1;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam int         DEPTH    = 1 << MEM_DEPTH_LOG2;

  logic [0:0]                state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic                      rd_q, rd_d;
  logic [MEM_DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [15:0]               wd_q, wd_d;
  logic [15:0]               rdata_q, rdata_d;
  logic                      halted_q, halted_d;
  logic [15:0]               mem [DEPTH];

  logic idle, busy_last, open, access, valid, illegal, halt_req, mem_we;
  // Address bits above the word index alias onto the same word by design.
  logic unused_addr_hi;

  assign unused_addr_hi = ^(dataAddr >> (MEM_DEPTH_LOG2 + 1));

  assign idle      = (state_q == S_IDLE);
  assign busy_last = (state_q == S_BUSY) && (cnt_q == 4'd0);
  assign open      = idle && !halted_q;
  assign access    = readEn | memWrt;
  assign valid     = open && !createDump && (readEn ^ memWrt) && !dataAddr[0];
  assign illegal   = open && ((readEn & memWrt) | (access & dataAddr[0]) | (createDump & access));
  assign halt_req  = open && createDump && !access;
  assign mem_we    = busy_last && !rd_q && !rst;

  assign stall    = valid || ((state_q == S_BUSY) && (cnt_q != 4'd0));
  assign done     = busy_last;
  assign err      = illegal;
  assign readData = rdata_q;
  assign halted   = halted_q;

  // Next-state: accept or reject in IDLE, count down in BUSY, and retire on the last cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rd_d     = rd_q;
    idx_d    = idx_q;
    wd_d     = wd_q;
    rdata_d  = rdata_q;
    halted_d = halted_q;
    if (state_q == S_IDLE) begin
      if (valid) begin
        state_d = S_BUSY;
        cnt_d   = CNT_INIT;
        rd_d    = readEn;
        idx_d   = dataAddr[MEM_DEPTH_LOG2:1];
        wd_d    = wrtData;
      end else if (halt_req) begin
        halted_d = 1'b1;
      end
    end else begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = S_IDLE;
        if (rd_q) rdata_d = mem[idx_q];
      end
    end
  end

  // Control and datapath registers; reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      rd_q     <= 1'b0;
      idx_q    <= '0;
      wd_q     <= 16'h0;
      rdata_q  <= 16'h0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
      idx_q    <= idx_d;
      wd_q     <= wd_d;
      rdata_q  <= rdata_d;
      halted_q <= halted_d;
    end
  end

  // Storage array is never reset; stores commit on the done cycle only.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= wd_q;
  end

endmodule

// File: tb/tb_mem_resp_ctrl.sv
// tb_mem_resp_ctrl: directed scenarios with a queue of expected load results.
module tb_mem_resp_ctrl;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        readEn = 1'b0, memWrt = 1'b0, createDump = 1'b0;
  logic [15:0] dataAddr = 16'h0, wrtData = 16'h0;
  logic [15:0] readData;
  logic        done, stall, err, halted;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  mem_resp_ctrl #(.LATENCY(LAT), .MEM_DEPTH_LOG2(8)) dut (
    .clk(clk), .rst(rst), .readEn(readEn), .memWrt(memWrt), .dataAddr(dataAddr),
    .wrtData(wrtData), .createDump(createDump), .readData(readData), .done(done),
    .stall(stall), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  // Called #1 after a rising edge. Drives one request for one cycle and watches
  // up to 20 cycles. Returns #1 after the edge that follows done, i.e. in cycle T+LAT+1.
  task automatic run_op(input logic rd, input logic wr, input logic dump,
                        input logic [15:0] addr, input logic [15:0] data,
                        output int st, output int done_c, output int errs,
                        output int overlap, output logic [15:0] rdata);
    st = 0; done_c = -1; errs = 0; overlap = 0;
    readEn = rd; memWrt = wr; createDump = dump; dataAddr = addr; wrtData = data;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (stall) st++;
      if (err) errs++;
      if ((done && stall) || (err && (stall || done))) overlap++;
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
      readEn = 1'b0; memWrt = 1'b0; createDump = 1'b0;
    end
    @(posedge clk); #1;
    readEn = 1'b0; memWrt = 1'b0; createDump = 1'b0;
    rdata = readData;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if ({stall, done, err, halted} !== 4'b0) begin n_fail++; $display("FAIL reset_ctl: got %b want 0000", {stall, done, err, halted}); end
    n_chk++; if (readData !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0000", readData); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    int st, dc, er, ov; logic [15:0] rd;
    run_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, st, dc, er, ov, rd);
    n_chk++; if (st !== LAT || dc !== LAT) begin n_fail++; $display("FAIL store_timing: stall=%0d done_at=%0d want %0d/%0d", st, dc, LAT, LAT); end
    exp_q.push_back(16'hBEEF);
    run_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (st !== LAT || dc !== LAT) begin n_fail++; $display("FAIL load_timing: stall=%0d done_at=%0d want %0d/%0d", st, dc, LAT, LAT); end
    n_chk++; if (ov !== 0 || er !== 0) begin n_fail++; $display("FAIL load_overlap: overlap=%0d err=%0d want 0/0", ov, er); end
    n_chk++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL load_data: got %h want %h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_back_to_back;
    int st, dc, er, ov; logic [15:0] rd;
    run_op(1'b0, 1'b1, 1'b0, 16'h0002, 16'h1111, st, dc, er, ov, rd);
    run_op(1'b0, 1'b1, 1'b0, 16'h0004, 16'h2222, st, dc, er, ov, rd);
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    for (int k = 0; k < 2; k++) begin
      run_op(1'b1, 1'b0, 1'b0, (k == 0) ? 16'h0002 : 16'h0004, 16'h0, st, dc, er, ov, rd);
      n_chk++; if (st !== LAT || dc !== LAT) begin n_fail++; $display("FAIL b2b_timing%0d: stall=%0d done_at=%0d want %0d/%0d", k, st, dc, LAT, LAT); end
      n_chk++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL b2b_data%0d: got %h want %h", k, rd, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_illegal;
    int st, dc, er, ov; logic [15:0] rd;
    run_op(1'b1, 1'b1, 1'b0, 16'h0010, 16'hDEAD, st, dc, er, ov, rd);
    n_chk++; if (er !== 1 || st !== 0 || dc !== -1) begin n_fail++; $display("FAIL illegal_both: err=%0d stall=%0d done_at=%0d want 1/0/-1", er, st, dc); end
    run_op(1'b1, 1'b0, 1'b0, 16'h0003, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (er !== 1 || st !== 0 || dc !== -1) begin n_fail++; $display("FAIL illegal_odd: err=%0d stall=%0d done_at=%0d want 1/0/-1", er, st, dc); end
    n_chk++; if (rd !== 16'h2222) begin n_fail++; $display("FAIL illegal_rdata_held: got %h want 2222", rd); end
    run_op(1'b0, 1'b1, 1'b1, 16'h0010, 16'hDEAD, st, dc, er, ov, rd);
    n_chk++; if (er !== 1 || st !== 0 || halted !== 1'b0) begin n_fail++; $display("FAIL illegal_dump: err=%0d stall=%0d halted=%b want 1/0/0", er, st, halted); end
    exp_q.push_back(16'hBEEF);
    run_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL illegal_mem: got %h want %h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_alias;
    int st, dc, er, ov; logic [15:0] rd;
    run_op(1'b0, 1'b1, 1'b0, 16'h0202, 16'hA5A5, st, dc, er, ov, rd);
    n_chk++; if (er !== 0 || dc !== LAT) begin n_fail++; $display("FAIL alias_store: err=%0d done_at=%0d want 0/%0d", er, dc, LAT); end
    exp_q.push_back(16'hA5A5);
    run_op(1'b1, 1'b0, 1'b0, 16'h0002, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL alias_data: got %h want %h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_reset_midbusy;
    int st, dc, er, ov; logic [15:0] rd;
    run_op(1'b0, 1'b1, 1'b0, 16'h0020, 16'h5555, st, dc, er, ov, rd);
    memWrt = 1'b1; dataAddr = 16'h0020; wrtData = 16'h1234;
    @(posedge clk); #1;
    memWrt = 1'b0;
    @(posedge clk); #2;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL midbusy_stall: got %b want 1", stall); end
    rst = 1'b1; #1;
    n_chk++; if ({stall, done, err, halted} !== 4'b0 || readData !== 16'h0) begin n_fail++; $display("FAIL async_reset: ctl=%b rdata=%h want 0000/0000", {stall, done, err, halted}, readData); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(16'h5555);
    run_op(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (rd !== exp_q[0]) begin n_fail++; $display("FAIL reset_discard: got %h want %h", rd, exp_q[0]); end
    void'(exp_q.pop_front());
  endtask

  task automatic test_halt;
    int st, dc, er, ov; logic [15:0] rd;
    createDump = 1'b1;
    @(negedge clk);
    n_chk++; if ({stall, err, halted} !== 3'b000) begin n_fail++; $display("FAIL halt_cycle: got %b want 000", {stall, err, halted}); end
    @(posedge clk); #1;
    createDump = 1'b0;
    n_chk++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_sticky: got %b want 1", halted); end
    run_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0BAD, st, dc, er, ov, rd);
    n_chk++; if (st !== 0 || dc !== -1 || er !== 0) begin n_fail++; $display("FAIL halt_store: stall=%0d done_at=%0d err=%0d want 0/-1/0", st, dc, er); end
    run_op(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (st !== 0 || dc !== -1 || er !== 0) begin n_fail++; $display("FAIL halt_illegal: stall=%0d done_at=%0d err=%0d want 0/-1/0", st, dc, er); end
    n_chk++; if (rd !== 16'h5555) begin n_fail++; $display("FAIL halt_rdata_frozen: got %h want 5555", rd); end
    rst = 1'b1; #1;
    n_chk++; if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_clear: got %b want 0", halted); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(16'hBEEF);
    run_op(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0, st, dc, er, ov, rd);
    n_chk++; if (rd !== exp_q[0] || dc !== LAT) begin n_fail++; $display("FAIL halt_mem: got %h done_at=%0d want %h/%0d", rd, dc, exp_q[0], LAT); end
    void'(exp_q.pop_front());
  endtask

  initial begin
    test_reset;
    test_store_load;
    test_back_to_back;
    test_illegal;
    test_alias;
    test_reset_midbusy;
    test_halt;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
